// File: rtl/vend_transaction_controller.sv
// One vending transaction: coin collection, product dispense over req/ack,
// then change or refund paid out one coin at a time through the hopper.
module vend_transaction_controller #(
    parameter int PRICE        = 40,
    parameter int CREDIT_W     = 7,
    parameter int DISP_TIMEOUT = 255
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                Coin_Valid,
    input  logic [1:0]          Coin_Code,
    output logic                Coin_Ready,
    input  logic                Cancel,
    output logic                Vend_Req,
    input  logic                Vend_Ack,
    output logic                Chg_Req,
    output logic [1:0]          Chg_Coin,
    input  logic                Chg_Ack,
    output logic [CREDIT_W-1:0] Credit,
    output logic                Reject,
    output logic                Fault
);

    localparam int CNT_W = $clog2(DISP_TIMEOUT + 1);
    localparam logic [CREDIT_W-1:0] PRICE_C  = CREDIT_W'(PRICE);
    localparam logic [CNT_W-1:0]    TMO_LAST = CNT_W'(DISP_TIMEOUT - 1);

    typedef enum logic [1:0] {COLLECT, VEND, CHANGE} state_t;

    state_t              state;
    logic [CNT_W-1:0]    tmo_cnt;
    logic [CREDIT_W-1:0] credit_acc;
    logic [CREDIT_W-1:0] credit_left;
    logic [CREDIT_W-1:0] credit_paid;

    function automatic logic [CREDIT_W-1:0] coin_value(input logic [1:0] code);
        case (code)
            2'b00:   return CREDIT_W'(10);
            2'b01:   return CREDIT_W'(20);
            2'b10:   return CREDIT_W'(50);
            default: return '0;
        endcase
    endfunction

    // Greedy payout: Rs20 while at least 20 remains, otherwise Rs10.
    function automatic logic [1:0] change_code(input logic [CREDIT_W-1:0] amount);
        return (amount >= CREDIT_W'(20)) ? 2'b01 : 2'b00;
    endfunction

    function automatic logic [CREDIT_W-1:0] change_value(input logic [1:0] code);
        return (code == 2'b01) ? CREDIT_W'(20) : CREDIT_W'(10);
    endfunction

    always_comb begin
        credit_acc = Credit;
        if (Coin_Valid)
            credit_acc = Credit + coin_value(Coin_Code);
    end

    assign credit_left = Credit - PRICE_C;
    assign credit_paid = Credit - change_value(Chg_Coin);
    assign Coin_Ready  = (state == COLLECT);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state    <= COLLECT;
            Credit   <= '0;
            tmo_cnt  <= '0;
            Vend_Req <= 1'b0;
            Chg_Req  <= 1'b0;
            Chg_Coin <= 2'b00;
            Reject   <= 1'b0;
            Fault    <= 1'b0;
        end else begin
            Reject <= 1'b0;
            Fault  <= 1'b0;
            case (state)
                COLLECT: begin
                    if (Coin_Valid && Coin_Code == 2'b11)
                        Reject <= 1'b1;
                    Credit <= credit_acc;
                    if (credit_acc >= PRICE_C) begin
                        state    <= VEND;
                        Vend_Req <= 1'b1;
                        tmo_cnt  <= '0;
                    end else if (Cancel && credit_acc != '0) begin
                        state    <= CHANGE;
                        Chg_Req  <= 1'b1;
                        Chg_Coin <= change_code(credit_acc);
                    end
                end
                VEND: begin
                    // An ack in the timeout cycle still counts as a sale.
                    if (Vend_Ack) begin
                        Vend_Req <= 1'b0;
                        Credit   <= credit_left;
                        if (credit_left != '0) begin
                            state    <= CHANGE;
                            Chg_Req  <= 1'b1;
                            Chg_Coin <= change_code(credit_left);
                        end else begin
                            state <= COLLECT;
                        end
                    end else if (tmo_cnt == TMO_LAST) begin
                        Fault    <= 1'b1;
                        Vend_Req <= 1'b0;
                        state    <= CHANGE;
                        Chg_Req  <= 1'b1;
                        Chg_Coin <= change_code(Credit);
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                CHANGE: begin
                    // Chg_Req idles low for one cycle between coins.
                    if (Chg_Req) begin
                        if (Chg_Ack) begin
                            Chg_Req <= 1'b0;
                            Credit  <= credit_paid;
                            if (credit_paid == '0)
                                state <= COLLECT;
                        end
                    end else begin
                        Chg_Req  <= 1'b1;
                        Chg_Coin <= change_code(Credit);
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end

endmodule

// File: tb/tb_vend_transaction_controller.sv
// Scoreboard bench: stimulus pushes expected events from a transaction-level model,
// a negedge monitor pops and compares them as the controller produces them.
module tb_vend_transaction_controller;

    localparam int PRICE        = 40;
    localparam int CREDIT_W     = 7;
    localparam int DISP_TIMEOUT = 255;

    localparam int EV_REJECT = 0;
    localparam int EV_VEND   = 1;
    localparam int EV_FAULT  = 2;
    localparam int EV_CHG    = 3;

    logic                Clk = 1'b0;
    logic                Reset;
    logic                Coin_Valid;
    logic [1:0]          Coin_Code;
    logic                Coin_Ready;
    logic                Cancel;
    logic                Vend_Req;
    logic                Vend_Ack;
    logic                Chg_Req;
    logic [1:0]          Chg_Coin;
    logic                Chg_Ack;
    logic [CREDIT_W-1:0] Credit;
    logic                Reject;
    logic                Fault;

    vend_transaction_controller #(
        .PRICE(PRICE), .CREDIT_W(CREDIT_W), .DISP_TIMEOUT(DISP_TIMEOUT)
    ) dut (
        .Clk(Clk), .Reset(Reset), .Coin_Valid(Coin_Valid), .Coin_Code(Coin_Code),
        .Coin_Ready(Coin_Ready), .Cancel(Cancel), .Vend_Req(Vend_Req), .Vend_Ack(Vend_Ack),
        .Chg_Req(Chg_Req), .Chg_Coin(Chg_Coin), .Chg_Ack(Chg_Ack), .Credit(Credit),
        .Reject(Reject), .Fault(Fault)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        int kind;
        int val;
        int credit;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    int  vend_rise_cyc = 0;
    int  cur_chg_coin = 0;
    int  m_credit = 0;
    bit  mon_en = 0;
    bit  withhold = 0;
    bit  chg_hold = 0;
    bit  prev_vreq = 0;
    bit  prev_creq = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_ev(input int kind, input int val, input int credit);
        ev_t e;
        e.kind = kind; e.val = val; e.credit = credit;
        exp_q.push_back(e);
    endtask

    // Refund/change is paid greedily: Rs20 coins while >= 20 remains, then Rs10.
    task automatic push_refund(input int amount);
        int amt = amount;
        while (amt > 0) begin
            if (amt >= 20) begin push_ev(EV_CHG, 1, amt); amt -= 20; end
            else           begin push_ev(EV_CHG, 0, amt); amt -= 10; end
        end
    endtask

    function automatic int coin_rs(input int code);
        case (code)
            0: return 10;
            1: return 20;
            2: return 50;
            default: return 0;
        endcase
    endfunction

    task automatic expect_ev(input int kind, input int val, input int credit, input string name);
        ev_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s unexpected event kind=%0d credit=%0d expected none", name, kind, credit);
        end else begin
            e = exp_q.pop_front();
            check({name, "_kind"}, kind, e.kind);
            if (kind == e.kind) begin
                check({name, "_val"}, val, e.val);
                check({name, "_credit"}, credit, e.credit);
            end
            cur_chg_coin = e.val;
        end
    endtask

    // Monitor
    always @(negedge Clk) begin
        cyc++;
        if (mon_en && !Reset) begin
            if (Reject)
                expect_ev(EV_REJECT, 0, int'(Credit), "reject");
            if (Fault) begin
                expect_ev(EV_FAULT, 0, int'(Credit), "fault");
                check("fault_latency", cyc - vend_rise_cyc, DISP_TIMEOUT);
                check("fault_vreq_low", int'(Vend_Req), 0);
            end
            if (Vend_Req && !prev_vreq) begin
                vend_rise_cyc = cyc;
                expect_ev(EV_VEND, 0, int'(Credit), "vend");
            end
            if (Chg_Req && !prev_creq)
                expect_ev(EV_CHG, int'(Chg_Coin), int'(Credit), "chg");
            else if (Chg_Req)
                check("chg_coin_stable", int'(Chg_Coin), cur_chg_coin);
        end
        prev_vreq = Vend_Req;
        prev_creq = Chg_Req;
    end

    // Dispenser and hopper responders, with occasional stray acks.
    initial begin
        int vdly = 0;
        int cdly = 0;
        Vend_Ack = 1'b0;
        Chg_Ack  = 1'b0;
        forever begin
            @(negedge Clk);
            Vend_Ack = 1'b0;
            Chg_Ack  = 1'b0;
            if (Vend_Req) begin
                if (!withhold) begin
                    if (vdly == 0) Vend_Ack = 1'b1;
                    else vdly--;
                end
            end else begin
                vdly = $urandom_range(0, 5);
                if ($urandom_range(0, 9) == 0) Vend_Ack = 1'b1;
            end
            if (Chg_Req) begin
                if (!chg_hold) begin
                    if (cdly == 0) Chg_Ack = 1'b1;
                    else cdly--;
                end
            end else begin
                cdly = $urandom_range(0, 3);
                if ($urandom_range(0, 9) == 0) Chg_Ack = 1'b1;
            end
        end
    end

    // One COLLECT cycle; the model decides whether the controller leaves COLLECT.
    task automatic drive_coin(input bit v, input int code, input bit cancel, output bit left);
        check("coin_ready_collect", int'(Coin_Ready), 1);
        Coin_Valid = v;
        Coin_Code  = 2'(code);
        Cancel     = cancel;
        left = 0;
        if (v) begin
            if (code == 3) push_ev(EV_REJECT, 0, m_credit);
            else m_credit += coin_rs(code);
        end
        if (m_credit >= PRICE) begin
            push_ev(EV_VEND, 0, m_credit);
            if (withhold) begin
                push_ev(EV_FAULT, 0, m_credit);
                push_refund(m_credit);
            end else begin
                push_refund(m_credit - PRICE);
            end
            left = 1;
        end else if (cancel && m_credit > 0) begin
            push_refund(m_credit);
            left = 1;
        end
        @(negedge Clk);
        Coin_Valid = 1'b0;
        Cancel     = 1'b0;
    endtask

    task automatic finish_txn();
        int n = 0;
        bit vend_seen = 0;
        while (!(Coin_Ready && !Vend_Req && !Chg_Req) && n < 1000) begin
            if (Vend_Req && !vend_seen) begin
                check("coin_ready_in_vend", int'(Coin_Ready), 0);
                vend_seen = 1;
            end
            if (!Coin_Ready) begin
                Coin_Valid = 1'($urandom_range(0, 1));
                Coin_Code  = 2'($urandom_range(0, 3));
                Cancel     = 1'($urandom_range(0, 1));
            end
            @(negedge Clk);
            n++;
        end
        Coin_Valid = 1'b0;
        Cancel     = 1'b0;
        if (n >= 1000) begin
            check("txn_done_bound", 0, 1);
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
        end
        check("final_credit", int'(Credit), 0);
        check("events_left", exp_q.size(), 0);
        m_credit = 0;
    endtask

    task automatic run_coins(input int codes[$], input bit cancel_after);
        bit left = 0;
        foreach (codes[i])
            if (!left) drive_coin(1'b1, codes[i], 1'b0, left);
        if (!left && cancel_after) drive_coin(1'b0, 0, 1'b1, left);
        finish_txn();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1);
    end

    initial begin
        bit left;
        Reset = 1'b1; Coin_Valid = 1'b0; Coin_Code = 2'b00; Cancel = 1'b0;
        repeat (3) @(negedge Clk);
        check("rst_credit", int'(Credit), 0);
        check("rst_vend_req", int'(Vend_Req), 0);
        check("rst_chg_req", int'(Chg_Req), 0);
        check("rst_chg_coin", int'(Chg_Coin), 0);
        check("rst_reject", int'(Reject), 0);
        check("rst_fault", int'(Fault), 0);
        check("rst_coin_ready", int'(Coin_Ready), 1);
        Reset = 1'b0;
        mon_en = 1;
        @(negedge Clk);

        run_coins('{0, 0, 1}, 0);
        run_coins('{1, 2}, 0);
        run_coins('{1, 0}, 1);
        drive_coin(1'b0, 0, 1'b1, left);
        run_coins('{3, 3, 2}, 0);
        withhold = 1;
        run_coins('{2}, 0);
        withhold = 0;

        // Asynchronous reset in the middle of a refund.
        chg_hold = 1;
        drive_coin(1'b1, 1, 1'b0, left);
        drive_coin(1'b1, 0, 1'b1, left);
        repeat (3) @(negedge Clk);
        check("pre_rst_credit", int'(Credit), 30);
        mon_en = 0;
        #2 Reset = 1'b1;
        #1;
        check("arst_credit", int'(Credit), 0);
        check("arst_chg_req", int'(Chg_Req), 0);
        check("arst_chg_coin", int'(Chg_Coin), 0);
        check("arst_vend_req", int'(Vend_Req), 0);
        check("arst_coin_ready", int'(Coin_Ready), 1);
        check("arst_reject_fault", int'(Reject) + int'(Fault), 0);
        exp_q.delete();
        m_credit = 0;
        chg_hold = 0;
        @(negedge Clk);
        Reset = 1'b0;
        mon_en = 1;
        @(negedge Clk);
        run_coins('{2}, 0);

        for (int t = 0; t < 30; t++) begin
            int k = 0;
            left = 0;
            withhold = ($urandom_range(0, 7) == 0);
            while (!left) begin
                bit v;
                int r;
                int code;
                bit c;
                v = ($urandom_range(0, 3) != 0);
                r = $urandom_range(0, 9);
                code = (r < 4) ? 0 : (r < 7) ? 1 : (r < 9) ? 2 : 3;
                c = ($urandom_range(0, 7) == 0);
                if (k >= 20) begin v = 1; code = 2; end
                drive_coin(v, code, c, left);
                k++;
            end
            finish_txn();
            withhold = 0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
